// File: rtl/multi_color_mask.sv
// Pipelined N-color chroma box classifier with shadow/active target banks.
// Optional per-frame hit counters are built when MULTI_COLOR_MASK_HIT_COUNT_EN is defined.
module multi_color_mask #(
  parameter int NUM_COLORS   = 4,
  parameter int YUV_WIDTH    = 8,
  parameter int THRESH_WIDTH = 10,
  parameter int CNT_WIDTH    = 20,
  parameter int AW           = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_we,
  input  logic [AW-1:0]                     cfg_addr,
  input  logic signed [YUV_WIDTH-1:0]       cfg_uTarget,
  input  logic signed [YUV_WIDTH-1:0]       cfg_vTarget,
  input  logic signed [THRESH_WIDTH-1:0]    cfg_uThresh,
  input  logic signed [THRESH_WIDTH-1:0]    cfg_vThresh,
  input  logic                              cfg_enable,
  input  logic signed [YUV_WIDTH-1:0]       U,
  input  logic signed [YUV_WIDTH-1:0]       V,
  input  logic                              in_valid,
  input  logic                              in_sof,
  input  logic                              in_eof,
  output logic [NUM_COLORS-1:0]             colorEncoding,
  output logic                              out_valid,
  output logic                              out_eof,
  output logic [NUM_COLORS*CNT_WIDTH-1:0]   hit_count,
  output logic                              count_valid
);

  localparam int EW = THRESH_WIDTH + 2;

  typedef logic signed [EW-1:0] ext_t;

  typedef struct packed {
    logic [YUV_WIDTH-1:0]    ut;
    logic [YUV_WIDTH-1:0]    vt;
    logic [THRESH_WIDTH-1:0] uth;
    logic [THRESH_WIDTH-1:0] vth;
    logic                    en;
  } entry_t;

  function automatic ext_t sext_y(input logic [YUV_WIDTH-1:0] x);
    return {{(EW-YUV_WIDTH){x[YUV_WIDTH-1]}}, x};
  endfunction

  function automatic ext_t sext_t(input logic [THRESH_WIDTH-1:0] x);
    return {{(EW-THRESH_WIDTH){x[THRESH_WIDTH-1]}}, x};
  endfunction

  entry_t sh  [NUM_COLORS];
  entry_t act [NUM_COLORS];
  entry_t sel [NUM_COLORS];
  entry_t wr_entry;
  logic   commit;

  assign commit   = in_valid && in_sof;
  assign wr_entry = {cfg_uTarget, cfg_vTarget, cfg_uThresh, cfg_vThresh, cfg_enable};

  // Commit copies the pre-write shadow; a coincident write stays pending in shadow.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_COLORS; i++) begin
        sh[i]  <= '0;
        act[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_COLORS; i++) begin
        if (commit)
          act[i] <= sh[i];
        if (cfg_we && (cfg_addr == AW'(i)))
          sh[i] <= wr_entry;
      end
    end
  end

  ext_t                  lo_u [NUM_COLORS];
  ext_t                  hi_u [NUM_COLORS];
  ext_t                  lo_v [NUM_COLORS];
  ext_t                  hi_v [NUM_COLORS];
  logic [NUM_COLORS-1:0] en_sel;

  // The sof pixel sees the bank it commits, hence the bypass to shadow.
  always_comb begin
    en_sel = '0;
    for (int unsigned i = 0; i < NUM_COLORS; i++) begin
      sel[i]    = commit ? sh[i] : act[i];
      lo_u[i]   = sext_y(sel[i].ut) - sext_t(sel[i].uth);
      hi_u[i]   = sext_y(sel[i].ut) + sext_t(sel[i].uth);
      lo_v[i]   = sext_y(sel[i].vt) - sext_t(sel[i].vth);
      hi_v[i]   = sext_y(sel[i].vt) + sext_t(sel[i].vth);
      en_sel[i] = sel[i].en;
    end
  end

  ext_t                  s1_u;
  ext_t                  s1_v;
  ext_t                  s1_lo_u [NUM_COLORS];
  ext_t                  s1_hi_u [NUM_COLORS];
  ext_t                  s1_lo_v [NUM_COLORS];
  ext_t                  s1_hi_v [NUM_COLORS];
  logic [NUM_COLORS-1:0] s1_en;
  logic                  s1_valid;
  logic                  s1_eof;

  always_ff @(posedge clk) begin
    s1_u  <= sext_y(U);
    s1_v  <= sext_y(V);
    s1_en <= en_sel;
    for (int unsigned i = 0; i < NUM_COLORS; i++) begin
      s1_lo_u[i] <= lo_u[i];
      s1_hi_u[i] <= hi_u[i];
      s1_lo_v[i] <= lo_v[i];
      s1_hi_v[i] <= hi_v[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_eof   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_eof   <= in_valid && in_eof;
    end
  end

  logic [NUM_COLORS-1:0] hit;

  // An inverted box (negative threshold) fails one of the two bounds by construction.
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_COLORS; i++) begin
      hit[i] = s1_en[i]
            && (s1_lo_u[i] <= s1_u) && (s1_u <= s1_hi_u[i])
            && (s1_lo_v[i] <= s1_v) && (s1_v <= s1_hi_v[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      colorEncoding <= '0;
      out_valid     <= 1'b0;
      out_eof       <= 1'b0;
    end else begin
      colorEncoding <= s1_valid ? hit : '0;
      out_valid     <= s1_valid;
      out_eof       <= s1_valid && s1_eof;
    end
  end

`ifdef MULTI_COLOR_MASK_HIT_COUNT_EN
  logic                 s1_sof;
  logic                 s2_sof;
  logic [CNT_WIDTH-1:0] cnt      [NUM_COLORS];
  logic [CNT_WIDTH-1:0] cnt_next [NUM_COLORS];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_sof <= 1'b0;
      s2_sof <= 1'b0;
    end else begin
      s1_sof <= in_valid && in_sof;
      s2_sof <= s1_valid && s1_sof;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_COLORS; i++) begin
      cnt_next[i] = cnt[i];
      if (out_valid) begin
        if (s2_sof)
          cnt_next[i] = CNT_WIDTH'(colorEncoding[i]);
        else if (colorEncoding[i] && (cnt[i] != '1))
          cnt_next[i] = cnt[i] + CNT_WIDTH'(1);
      end
    end
  end

  // hit_count snapshots the count including the eof pixel itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_COLORS; i++)
        cnt[i] <= '0;
      hit_count   <= '0;
      count_valid <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_COLORS; i++) begin
        cnt[i] <= cnt_next[i];
        if (out_valid && out_eof)
          hit_count[i*CNT_WIDTH +: CNT_WIDTH] <= cnt_next[i];
      end
      count_valid <= out_valid && out_eof;
    end
  end
`else
  assign hit_count   = '0;
  assign count_valid = 1'b0;
`endif

endmodule

// File: tb/tb_multi_color_mask.sv
// Scoreboard bench for multi_color_mask: a box-distance reference model predicts
// per-pixel hits and per-frame counts; a negedge monitor checks DUT outputs.
module tb_multi_color_mask;

  localparam int NC   = 3;
  localparam int YW   = 8;
  localparam int TW   = 10;
  localparam int CW   = 6;
  localparam int AW   = 2;
  localparam int CMAX = (1 << CW) - 1;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   cfg_we;
  logic [AW-1:0]          cfg_addr;
  logic signed [YW-1:0]   cfg_uTarget, cfg_vTarget;
  logic signed [TW-1:0]   cfg_uThresh, cfg_vThresh;
  logic                   cfg_enable;
  logic signed [YW-1:0]   U, V;
  logic                   in_valid, in_sof, in_eof;
  logic [NC-1:0]          colorEncoding;
  logic                   out_valid, out_eof;
  logic [NC*CW-1:0]       hit_count;
  logic                   count_valid;

  multi_color_mask #(
    .NUM_COLORS(NC),
    .YUV_WIDTH(YW),
    .THRESH_WIDTH(TW),
    .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_uTarget(cfg_uTarget), .cfg_vTarget(cfg_vTarget),
    .cfg_uThresh(cfg_uThresh), .cfg_vThresh(cfg_vThresh),
    .cfg_enable(cfg_enable),
    .U(U), .V(V),
    .in_valid(in_valid), .in_sof(in_sof), .in_eof(in_eof),
    .colorEncoding(colorEncoding),
    .out_valid(out_valid), .out_eof(out_eof),
    .hit_count(hit_count), .count_valid(count_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model state
  int sh_ut[NC], sh_vt[NC], sh_uth[NC], sh_vth[NC];
  bit sh_en[NC];
  int ac_ut[NC], ac_vt[NC], ac_uth[NC], ac_vth[NC];
  bit ac_en[NC];
  int cnt_m[NC];

  typedef struct {
    logic [NC-1:0] enc;
    bit            eof;
    int            cyc;
  } exp_t;

  exp_t             pq[$];
  logic [NC*CW-1:0] cq[$];

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic logic [NC-1:0] classify(input int u, input int v);
    logic [NC-1:0] r = '0;
    for (int i = 0; i < NC; i++)
      r[i] = ac_en[i] && (iabs(u - ac_ut[i]) <= ac_uth[i]) && (iabs(v - ac_vt[i]) <= ac_vth[i]);
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NC; i++) begin
      sh_ut[i] = 0; sh_vt[i] = 0; sh_uth[i] = 0; sh_vth[i] = 0; sh_en[i] = 0;
      ac_ut[i] = 0; ac_vt[i] = 0; ac_uth[i] = 0; ac_vth[i] = 0; ac_en[i] = 0;
      cnt_m[i] = 0;
    end
  endtask

  task automatic step(input bit vld, input bit sof, input bit eof, input int u, input int v,
                      input bit we = 0, input int addr = 0, input int ut = 0, input int vt = 0,
                      input int uth = 0, input int vth = 0, input bit en = 0);
    logic [NC-1:0]    enc;
    logic [NC*CW-1:0] snap;
    @(posedge clk); #1;
    in_valid = vld; in_sof = sof; in_eof = eof;
    U = YW'(u); V = YW'(v);
    cfg_we = we; cfg_addr = AW'(addr);
    cfg_uTarget = YW'(ut); cfg_vTarget = YW'(vt);
    cfg_uThresh = TW'(uth); cfg_vThresh = TW'(vth);
    cfg_enable = en;
    if (vld) begin
      if (sof) begin
        ac_ut = sh_ut; ac_vt = sh_vt; ac_uth = sh_uth; ac_vth = sh_vth; ac_en = sh_en;
      end
      enc = classify(u, v);
      pq.push_back('{enc, eof, cyc});
      for (int i = 0; i < NC; i++) begin
        if (sof) cnt_m[i] = enc[i] ? 1 : 0;
        else if (enc[i] && cnt_m[i] < CMAX) cnt_m[i]++;
      end
      if (eof) begin
        snap = '0;
        for (int i = 0; i < NC; i++) snap[i*CW +: CW] = CW'(cnt_m[i]);
        cq.push_back(snap);
      end
    end
    if (we && addr < NC) begin
      sh_ut[addr] = ut; sh_vt[addr] = vt; sh_uth[addr] = uth; sh_vth[addr] = vth; sh_en[addr] = en;
    end
  endtask

  task automatic cfg(input int addr, input int ut, input int vt, input int uth, input int vth, input bit en);
    step(0, 0, 0, 0, 0, 1, addr, ut, vt, uth, vth, en);
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0);
  endtask

  // Frame with an exact number of color2 hits (color2 box is (0,0)+-3 when called).
  task automatic counted_frame(input int npix, input int nhit);
    int left = nhit;
    int u, v;
    bit h;
    for (int p = 0; p < npix; p++) begin
      h = ($urandom_range(npix - p - 1, 0) < left);
      if (h) begin
        left--;
        u = $urandom_range(6, 0) - 3;
        v = $urandom_range(6, 0) - 3;
      end else begin
        u = $urandom_range(100, 20);
        v = $urandom_range(6, 0) - 3;
      end
      step(1, p == 0, p == npix - 1, u, v);
      if ($urandom_range(4, 0) == 0) idle();
    end
  endtask

  // Monitor
  bit   cv_expect = 0;
  exp_t e;
  always @(negedge clk) begin
`ifdef MULTI_COLOR_MASK_HIT_COUNT_EN
    chk("count_valid", count_valid, cv_expect);
    if (count_valid) begin
      if (cq.size() == 0) begin
        checks++; errors++;
        $display("FAIL count_unexpected: got count_valid=1 expected no report");
      end else begin
        chk("hit_count", hit_count, cq.pop_front());
      end
    end
`else
    chk("count_valid_off", count_valid, 0);
    chk("hit_count_off", hit_count, 0);
`endif
    if (out_valid) begin
      if (pq.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got out_valid=1 expected no pixel");
      end else begin
        e = pq.pop_front();
        chk("colorEncoding", colorEncoding, e.enc);
        chk("out_eof", out_eof, e.eof);
        chk("latency", cyc - e.cyc, 2);
      end
    end else begin
      chk("idle_enc", colorEncoding, 0);
      chk("idle_eof", out_eof, 0);
    end
    cv_expect = out_valid && out_eof;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int u, v;
    rst = 1; cfg_we = 0; cfg_addr = '0; cfg_uTarget = '0; cfg_vTarget = '0;
    cfg_uThresh = '0; cfg_vThresh = '0; cfg_enable = 0;
    U = '0; V = '0; in_valid = 0; in_sof = 0; in_eof = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1 rst = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_enc", colorEncoding, 0);
    chk("rst_hit_count", hit_count, 0);
    chk("rst_count_valid", count_valid, 0);

    // All channels disabled after reset
    step(1, 0, 0, 10, -5);
    // Basic box and its inclusive edge
    cfg(0, 20, -10, 5, 5, 1);
    step(1, 1, 0, 25, -15);
    step(1, 0, 0, 26, -15);
    step(1, 0, 0, 15, -5);
    // Mid-frame write waits for sof; coincident write waits for the following sof
    cfg(1, -50, 60, 8, 3, 1);
    step(1, 0, 0, -50, 60);
    step(1, 1, 0, -50, 60);
    step(1, 1, 0, -50, 60, 1, 1, 0, 0, 1, 1, 1);
    step(1, 0, 0, -50, 60);
    step(1, 1, 0, -50, 60);
    step(1, 0, 0, 0, 1);
    // Extreme target without wrap; negative threshold never matches; out-of-range address ignored
    cfg(2, -128, -128, 10, 10, 1);
    cfg(0, 20, -10, -1, 5, 1);
    cfg(3, 0, 0, 100, 100, 1);
    step(1, 1, 0, -128, -128);
    step(1, 0, 0, -118, -128);
    step(1, 0, 0, 20, -10);
    step(1, 0, 1, 127, 127);
    repeat (3) idle();

    // Counter frames
    cfg(2, 0, 0, 3, 3, 1);
    counted_frame(100, 37);
    counted_frame(60, 12);
    counted_frame(80, 70);
    step(1, 1, 1, 0, 0);
    step(1, 0, 0, 1, 1);
    step(1, 0, 1, 50, 0);
    repeat (3) idle();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      bit we = ($urandom_range(4, 0) == 0);
      bit vld = ($urandom_range(9, 0) < 7);
      int a = $urandom_range(3, 0);
      int tu = $urandom_range(255, 0) - 128;
      int tv = $urandom_range(255, 0) - 128;
      int k = $urandom_range(NC - 1, 0);
      u = sh_ut[k] + $urandom_range(80, 0) - 40;
      v = sh_vt[k] + $urandom_range(80, 0) - 40;
      if (u > 127) u = 127;
      if (u < -128) u = -128;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      step(vld, $urandom_range(9, 0) == 0, $urandom_range(9, 0) == 0, u, v,
           we, a, tu, tv, $urandom_range(100, 0) - 5, $urandom_range(100, 0) - 5,
           $urandom_range(3, 0) != 0);
    end
    repeat (3) idle();

    // Reset while an eof pixel sits in stage 1
    step(1, 1, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    @(posedge clk); #1;
    rst = 1; in_valid = 0; in_sof = 0; in_eof = 0; cfg_we = 0;
    @(posedge clk); #1;
    pq.delete();
    cq.delete();
    model_reset();
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_enc", colorEncoding, 0);
    chk("midrst_eof", out_eof, 0);
    chk("midrst_count_valid", count_valid, 0);
    chk("midrst_hit_count", hit_count, 0);
    rst = 0;
    step(1, 1, 1, 10, 10);
    repeat (5) idle();

    chk("pixel_queue_drained", pq.size(), 0);
`ifdef MULTI_COLOR_MASK_HIT_COUNT_EN
    chk("count_queue_drained", cq.size(), 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
